ifetch_queue: RTL

Parametrised next-generation instruction fetch unit. It issues one-at-a-time fetch requests to the icache and pre-decodes RV32I/RVC length and control flow. Fetched instructions are buffered in a DEPTH-entry FIFO and handed to the decoder through a valid/ready handshake. Fetch stops on any control-flow instruction until the ALU, the decoder or a ROB flush supplies the next PC.

---
 rtl/ifetch_queue_pkg.sv | 28 ++
 rtl/ifetch_queue_fifo.sv | 49 ++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared FSM states, pre-decode field constants and control-flow helpers
package ifetch_queue_pkg;
  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_WAIT    = 2'd1,
    S_BR_WAIT = 2'd2,
    S_DISCARD = 2'd3
  } state_t;
  localparam int INST32_W = 32;
  localparam int INST16_W = 16;
  localparam logic [1:0] Q_RV32 = 2'b11;
  localparam logic [2:0] OP_CF = 3'b110;
  localparam logic [1:0] RVC_Q1 = 2'b01;
  localparam logic [1:0] RVC_Q2 = 2'b10;
  localparam logic [2:0] F3_C_JAL = 3'b001;
  localparam logic [2:0] F3_C_J = 3'b101;
  localparam logic [2:0] F3_C_BEQZ = 3'b110;
  localparam logic [2:0] F3_C_BNEZ = 3'b111;
  localparam logic [2:0] F3_C_JR = 3'b100;
  function automatic logic rv32_cf(input logic [6:0] op);
    return op[1:0] == Q_RV32 && op[6:4] == OP_CF;
  endfunction
  function automatic logic rvc_cf(input logic [15:0] i);
    return (i[1:0] == RVC_Q1 && (i[15:13] == F3_C_JAL || i[15:13] == F3_C_J ||
                                 i[15:13] == F3_C_BEQZ || i[15:13] == F3_C_BNEZ)) ||
           (i[1:0] == RVC_Q2 && i[15:13] == F3_C_JR && i[6:2] == 5'd0 && i[11:7] != 5'd0);
  endfunction
endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer with synchronous clear, freeze enable and occupancy count
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable, 0 freezes all state
//   clr        : empties the buffer, overriding push/pop
//   push/din   : enqueue (caller guarantees not full unless popping)
//   pop        : dequeue (caller guarantees not empty)
//   dout       : entry at the read pointer, combinational
//   count      : occupancy 0..DEPTH
module ifq_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] rd, wr;
  assign dout = mem[rd];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (clr) begin
        rd <= '0;
        wr <= '0;
        count <= '0;
      end else begin
        if (push) mem[wr] <= din;
        wr <= push ? wr + PW'(1) : wr;
        rd <= pop ? rd + PW'(1) : rd;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(en && !clr && push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: single-outstanding instruction fetch with RV32I/RVC pre-decode and decode FIFO
//   Optional feature macro IFETCH_RVC_EN: when defined, 16-bit instructions are recognised
//   (PC += 2, is_c_out meaningful, compressed control flow stalls fetch); otherwise every
//   response is 32-bit and is_c_out is 0.
//   clk, rst_n_in              : clock, asynchronous active-low reset
//   rdy_in                     : global enable, 0 freezes all state
//   icache_req/pc/rdy/inst     : level request held until the one-cycle response
//   deq_valid/ready, inst_out, pc_out, is_c_out : FIFO head to the decoder
//   pred_en/pred_pc            : pulse when a control-flow instruction is enqueued
//   flush/rob2if               : misprediction redirect, highest priority
//   alu2if_cont/alu2if         : resolved branch target (wins over decoder)
//   dec_upd/dec2if             : decoder-computed jump target
//   count_out                  : FIFO occupancy
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  output logic                     icache_req,
  output logic [ADDR_W-1:0]        icache_pc,
  input  logic                     icache_rdy,
  input  logic [INST_W-1:0]        icache_inst,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [INST_W-1:0]        inst_out,
  output logic [ADDR_W-1:0]        pc_out,
  output logic                     is_c_out,
  output logic                     pred_en,
  output logic [ADDR_W-1:0]        pred_pc,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        rob2if,
  input  logic                     alu2if_cont,
  input  logic [ADDR_W-1:0]        alu2if,
  input  logic                     dec_upd,
  input  logic [ADDR_W-1:0]        dec2if,
  output logic [$clog2(DEPTH):0]   count_out
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = INST_W + ADDR_W + 1;
  state_t state, state_d;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_d, req_pc, req_pc_d, pred_pc_d;
  logic pred_en_d, is_c, cf, push, pop;
  logic [INST_W-1:0] inst_ext;
  logic [EW-1:0] head;
`ifdef IFETCH_RVC_EN
  assign is_c = icache_inst[1:0] != Q_RV32;
`else
  assign is_c = 1'b0;
`endif
  assign inst_ext = is_c ? {{(INST_W-INST16_W){1'b0}}, icache_inst[INST16_W-1:0]} : icache_inst;
  assign cf = is_c ? rvc_cf(icache_inst[INST16_W-1:0]) : rv32_cf(icache_inst[6:0]);
  // Gated by reset so the request is low while the FSM is held in FETCH by reset.
  assign icache_req = rst_n_in && (state == S_WAIT || state == S_DISCARD ||
                                   (state == S_FETCH && count_out != CW'(DEPTH)));
  assign icache_pc = state == S_FETCH ? fetch_pc : req_pc;
  assign deq_valid = count_out != '0;
  assign push = state == S_WAIT && icache_rdy && !flush;
  assign pop = deq_ready && deq_valid && !flush;
  assign {inst_out, pc_out, is_c_out} = head;
  always_comb begin
    state_d = state;
    fetch_pc_d = fetch_pc;
    req_pc_d = req_pc;
    pred_en_d = 1'b0;
    pred_pc_d = pred_pc;
    if (flush) begin
      // A request issued this cycle (or still pending) must have its response dropped.
      fetch_pc_d = rob2if;
      req_pc_d = icache_pc;
      state_d = icache_req && !icache_rdy ? S_DISCARD : S_FETCH;
    end else begin
      case (state)
        S_FETCH: if (icache_req) begin
          state_d = S_WAIT;
          req_pc_d = fetch_pc;
        end
        S_WAIT: if (icache_rdy) begin
          state_d = cf ? S_BR_WAIT : S_FETCH;
          fetch_pc_d = req_pc + (is_c ? ADDR_W'(2) : ADDR_W'(4));
          pred_en_d = cf;
          pred_pc_d = cf ? req_pc : pred_pc;
        end
        S_BR_WAIT: if (alu2if_cont || dec_upd) begin
          state_d = S_FETCH;
          fetch_pc_d = alu2if_cont ? alu2if : dec2if;
        end
        S_DISCARD: if (icache_rdy) state_d = S_FETCH;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= S_FETCH;
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      pred_en <= 1'b0;
      pred_pc <= '0;
    end else if (rdy_in) begin
      state <= state_d;
      fetch_pc <= fetch_pc_d;
      req_pc <= req_pc_d;
      pred_en <= pred_en_d;
      pred_pc <= pred_pc_d;
    end
  end
  ifq_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n_in),
    .en(rdy_in),
    .clr(flush),
    .push(push),
    .pop(pop),
    .din({inst_ext, req_pc, is_c}),
    .dout(head),
    .count(count_out)
  );
endmodule
